// File: rtl/spi_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl_if
// Host-side request/response bundle for the SPI master controller.
//   start     : transaction request (accepted only while the controller is idle)
//   with_data : 1 = command byte followed by 32 data bits, 0 = command byte only
//   cmd       : command byte, shifted out first (bit0 selects the slave data reg)
//   wdata     : data word shifted out in the data phase
//   busy      : controller owns the link
//   done      : one-cycle pulse when NCS rises; status/rdata valid from then
//   status    : MISO byte captured during the command phase
//   rdata     : MISO word captured during the data phase
// Modports: master = requester (host / bench), slave = the controller.
// -----------------------------------------------------------------------------
interface spi_master_ctrl_if;
  logic        start;
  logic        with_data;
  logic [7:0]  cmd;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [7:0]  status;
  logic [31:0] rdata;

  modport master (
    output start, with_data, cmd, wdata,
    input  busy, done, status, rdata
  );

  modport slave (
    input  start, with_data, cmd, wdata,
    output busy, done, status, rdata
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// SPI mode-0 master. One transaction shifts out an 8-bit command, optionally
// followed by 32 data bits, MSB first, while capturing MISO into status
// (command phase) and rdata (data phase). SCK is clk divided by 2*CLK_DIV.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   host    : request/response bundle (spi_master_ctrl_if.slave)
//   sck_o   : SPI clock, idles low
//   mosi_o  : SPI data out, 0 while NCS is high
//   ncs_o   : SPI chip select, active low
//   miso_i  : SPI data in
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int CLK_DIV  = 4,  // clk cycles per SCK half-period (2..255)
  parameter int CS_SETUP = 4,  // NCS fall to first SCK low phase (>=1)
  parameter int CS_HOLD  = 4,  // last SCK fall to NCS rise (>=1)
  parameter int CS_IDLE  = 8   // NCS high time before busy drops (>=1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_ctrl_if.slave      host,
  output logic                  sck_o,
  output logic                  mosi_o,
  output logic                  ncs_o,
  input  logic                  miso_i
);

  localparam int HW   = $clog2(CLK_DIV + 1);
  localparam int CMAX = (CS_SETUP > CS_HOLD) ?
                        ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                        ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [39:0]     tx_q, tx_d;
  logic [39:0]     rx_q, rx_d;
  logic            long_q, long_d;     // 40-bit transaction
  logic [HW-1:0]   hcnt_q, hcnt_d;     // position within an SCK half-period
  logic [5:0]      bcnt_q, bcnt_d;     // bit index within the transaction
  logic [CW-1:0]   cnt_q, cnt_d;       // SETUP / HOLD / GAP duration counter
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            ncs_q, ncs_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      status_q, status_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [5:0]      last_bit;

  assign last_bit = long_q ? 6'd39 : 6'd7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      long_q   <= 1'b0;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      cnt_q    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      ncs_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      long_q   <= long_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      cnt_q    <= cnt_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      ncs_q    <= ncs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    long_d   = long_q;
    hcnt_d   = hcnt_q;
    bcnt_d   = bcnt_q;
    cnt_d    = cnt_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    ncs_d    = ncs_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    status_d = status_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (host.start) begin
          tx_d    = {host.cmd, host.wdata};
          long_d  = host.with_data;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = host.cmd[7];
          sck_d   = 1'b0;
          hcnt_d  = '0;
          bcnt_d  = '0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (hcnt_q == HALF_LAST) begin
          hcnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // End of the high phase: MISO has been stable since the slave's
            // previous SCK fall, so it is sampled here without a synchroniser.
            // The TX register rotates so every bit stays live; the bits that
            // wrap round are never driven while a bit is still owed.
            sck_d  = 1'b0;
            rx_d   = {rx_q[38:0], miso_i};
            tx_d   = {tx_q[38:0], tx_q[39]};
            mosi_d = tx_q[38];
            if (bcnt_q == last_bit) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              bcnt_d = bcnt_q + 6'd1;
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ncs_d  = 1'b1;
          mosi_d = 1'b0;
          done_d = 1'b1;
          cnt_d  = '0;
          if (long_q) begin
            status_d = rx_q[39:32];
            rdata_d  = rx_q[31:0];
          end else begin
            status_d = rx_q[7:0];
          end
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ncs_d   = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sck_o       = sck_q;
  assign mosi_o      = mosi_q;
  assign ncs_o       = ncs_q;
  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.status = status_q;
  assign host.rdata  = rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Scoreboard bench for spi_master_ctrl. The main instance (CLK_DIV=4) talks to
// a behavioural mode-0 SPI slave; every issued transaction pushes its expected
// result, and a monitor pops and compares on each done pulse. Two further
// instances (CLK_DIV=2 and 255) are used for SCK timing measurements.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl_if h4 ();
  spi_master_ctrl_if h2 ();
  spi_master_ctrl_if h255 ();

  logic sck4, mosi4, ncs4;
  logic miso4 = 1'b0;
  logic sck2, mosi2, ncs2;
  logic sck255, mosi255, ncs255;
  logic miso_zero = 1'b0;

  spi_master_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .host(h4),
    .sck_o(sck4), .mosi_o(mosi4), .ncs_o(ncs4), .miso_i(miso4)
  );
  spi_master_ctrl #(.CLK_DIV(2)) dut_div2 (
    .clk(clk), .rst_n(rst_n), .host(h2),
    .sck_o(sck2), .mosi_o(mosi2), .ncs_o(ncs2), .miso_i(miso_zero)
  );
  spi_master_ctrl #(.CLK_DIV(255)) dut_div255 (
    .clk(clk), .rst_n(rst_n), .host(h255),
    .sck_o(sck255), .mosi_o(mosi255), .ncs_o(ncs255), .miso_i(miso_zero)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural SPI slave (mode 0) ----------------
  logic [7:0]  slv_status = 8'h3A;
  logic [31:0] slv_d0 = 32'h01234567;
  logic [31:0] slv_d1 = 32'h11223344;
  logic [39:0] slv_rx = '0;
  logic [39:0] slv_tx = '0;
  logic        sck_prev = 1'b0;
  int          bitn = 0;
  int          rises = 0;

  always @(negedge ncs4 or posedge sck4 or negedge sck4) begin
    if (ncs4 == 1'b0) begin
      if (sck4 && !sck_prev) begin
        slv_rx = {slv_rx[38:0], mosi4};
        bitn++;
        rises++;
        if (bitn == 8) slv_tx[31:0] = slv_rx[0] ? slv_d1 : slv_d0;
      end else if (!sck4 && sck_prev) begin
        miso4 = (bitn < 40) ? slv_tx[39 - bitn] : 1'b0;
      end else begin
        bitn   = 0;
        rises  = 0;
        slv_rx = '0;
        slv_tx = {slv_status, 32'h0};
        miso4  = slv_tx[39];
      end
    end
    sck_prev = sck4;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0]  status;
    logic [31:0] rdata;
    int          rises;
    logic [39:0] mosi;
    int          start_cyc;
    int          latency;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_rdata = '0;

  task automatic push_exp(input logic [7:0] c, input logic wd, input logic [31:0] w);
    exp_t e;
    int   nb;
    nb = wd ? 40 : 8;
    e.status    = 8'h3A;
    if (wd) model_rdata = c[0] ? 32'h11223344 : 32'h01234567;
    e.rdata     = model_rdata;
    e.rises     = nb;
    e.mosi      = wd ? {c, w} : {32'h0, c};
    e.start_cyc = cyc;
    e.latency   = 1 + 4 + 2 * 4 * nb + 4;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (h4.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("status", {56'h0, h4.status}, {56'h0, e.status});
        chk("rdata", {32'h0, h4.rdata}, {32'h0, e.rdata});
        chk("sck_rises", 64'(rises), 64'(e.rises));
        chk("mosi_bits", {24'h0, slv_rx}, {24'h0, e.mosi});
        chk("done_latency", 64'(cyc - e.start_cyc), 64'(e.latency));
        chk("ncs_at_done", {63'h0, ncs4}, 64'h1);
        chk("mosi_at_done", {63'h0, mosi4}, 64'h0);
        $display("txn mosi=%010h status=%02h rdata=%08h rises=%0d latency=%0d",
                 slv_rx, h4.status, h4.rdata, rises, cyc - e.start_cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle4();
    int n = 0;
    while (h4.busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (h4.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=%0b required=0", h4.busy);
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] c, input logic wd, input logic [31:0] w, input bit push);
    @(negedge clk);
    h4.start     = 1'b1;
    h4.cmd       = c;
    h4.with_data = wd;
    h4.wdata     = w;
    if (push) push_exp(c, wd, w);
    @(negedge clk);
    h4.start = 1'b0;
    h4.cmd   = ~c;          // later changes must not leak into the transaction
    h4.wdata = ~w;
  endtask

  function automatic logic sck_of(input int div);
    return (div == 2) ? sck2 : sck255;
  endfunction

  function automatic logic ncs_of(input int div);
    return (div == 2) ? ncs2 : ncs255;
  endfunction

  function automatic logic busy_of(input int div);
    return (div == 2) ? h2.busy : h255.busy;
  endfunction

  task automatic measure(input int div);
    int  t_ncs, t_r1, t_f1, t_r2, n, nrise;
    logic prev;
    t_ncs = -1; t_r1 = -1; t_f1 = -1; t_r2 = -1; nrise = 0;
    @(negedge clk);
    if (div == 2) h2.start = 1'b1; else h255.start = 1'b1;
    @(negedge clk);
    h2.start = 1'b0;
    h255.start = 1'b0;
    if (ncs_of(div) == 1'b0) t_ncs = cyc;
    chk("ncs_low_after_start", {63'h0, ncs_of(div)}, 64'h0);
    prev = sck_of(div);
    n = 0;
    while (busy_of(div) === 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
      if (sck_of(div) && !prev) begin
        nrise++;
        if (t_r1 < 0) t_r1 = cyc;
        else if (t_r2 < 0) t_r2 = cyc;
      end
      if (!sck_of(div) && prev && t_f1 < 0) t_f1 = cyc;
      prev = sck_of(div);
    end
    chk("measure_idle", {63'h0, busy_of(div)}, 64'h0);
    chk("setup_to_first_rise", 64'(t_r1 - t_ncs), 64'(4 + div));
    chk("high_half_period", 64'(t_f1 - t_r1), 64'(div));
    chk("low_half_period", 64'(t_r2 - t_f1), 64'(div));
    chk("rise_count", 64'(nrise), 64'd8);
    $display("txn div=%0d setup_to_rise=%0d high=%0d low=%0d rises=%0d",
             div, t_r1 - t_ncs, t_f1 - t_r1, t_r2 - t_f1, nrise);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_before, n;

    h4.start = 1'b0; h4.with_data = 1'b0; h4.cmd = '0; h4.wdata = '0;
    h2.start = 1'b0; h2.with_data = 1'b0; h2.cmd = 8'hC3; h2.wdata = '0;
    h255.start = 1'b0; h255.with_data = 1'b0; h255.cmd = 8'h3C; h255.wdata = '0;

    repeat (3) @(negedge clk);
    chk("reset_ncs", {63'h0, ncs4}, 64'h1);
    chk("reset_sck", {63'h0, sck4}, 64'h0);
    chk("reset_mosi", {63'h0, mosi4}, 64'h0);
    chk("reset_busy", {63'h0, h4.busy}, 64'h0);
    chk("reset_done", {63'h0, h4.done}, 64'h0);
    chk("reset_status", {56'h0, h4.status}, 64'h0);
    chk("reset_rdata", {32'h0, h4.rdata}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8-bit, 40-bit reads of both registers, 40-bit write, 8-bit keeps rdata
    issue(8'hA5, 1'b0, 32'hCAFEF00D, 1'b1);
    chk("busy_after_start", {63'h0, h4.busy}, 64'h1);
    wait_idle4();
    issue(8'h01, 1'b1, 32'h00000000, 1'b1);
    wait_idle4();
    issue(8'h00, 1'b1, 32'h00000000, 1'b1);
    wait_idle4();
    issue(8'h01, 1'b1, 32'hDEADBEEF, 1'b1);
    wait_idle4();
    issue(8'h5C, 1'b0, 32'h0F0F0F0F, 1'b1);
    wait_idle4();

    // start held high the whole time: one transaction, then a second one
    // accepted in the very cycle busy falls
    done_before = done_cnt;
    @(negedge clk);
    h4.start = 1'b1; h4.cmd = 8'h81; h4.with_data = 1'b0; h4.wdata = '0;
    push_exp(8'h81, 1'b0, 32'h0);
    @(negedge clk);
    n = 0;
    while (h4.busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("single_txn_while_busy", 64'(done_cnt - done_before), 64'd1);
    push_exp(8'h81, 1'b0, 32'h0);
    @(negedge clk);
    chk("back_to_back_busy", {63'h0, h4.busy}, 64'h1);
    h4.start = 1'b0;
    wait_idle4();
    chk("back_to_back_done_count", 64'(done_cnt - done_before), 64'd2);

    // asynchronous reset in the middle of the shift phase
    done_before = done_cnt;
    issue(8'hFF, 1'b1, 32'hFFFFFFFF, 1'b0);
    n = 0;
    while (!(rises >= 3 && sck4 === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mid_shift_reached", {63'h0, sck4}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ncs", {63'h0, ncs4}, 64'h1);
    chk("async_rst_sck", {63'h0, sck4}, 64'h0);
    chk("async_rst_mosi", {63'h0, mosi4}, 64'h0);
    chk("async_rst_busy", {63'h0, h4.busy}, 64'h0);
    model_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("no_done_after_reset", 64'(done_cnt - done_before), 64'd0);

    // recovery after reset
    issue(8'h3D, 1'b0, 32'h0, 1'b1);
    wait_idle4();

    // SCK timing at the divider extremes
    measure(2);
    measure(255);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
